dmem_mshr_ctrl: RTL
===================

Name: dmem_mshr_ctrl

Overview:
- Data-memory controller behind the memory stage's mmio interface: direct-mapped, one-word-line, write-through data cache plus an in-order MSHR queue for non-blocking load misses.
- Answers every pipeline mmio request in the same cycle with exactly one of hit_ack, miss_send or passive_stall.
- Sequences refills over a single backing-memory port, then re-injects completed loads via load_done_stall/regD_done.

Parameters:
- SETS, 16, cache sets (power of 2, ≥2); index = addr[2+:log2(SETS)], tag = addr[31:2+log2(SETS)].
- MSHR_DEPTH, 4, outstanding load-miss entries; must equal the memory stage's MSHR tracking depth.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mmio_req  in  1  pipeline request valid
- mmio_lw  in  1  1=load, 0=store
- mmio_addr  in  32  word address; bits [1:0] ignored
- mmio_data_write  in  32  store data
- mmio_regD  in  5  load destination register
- mmio_data_read  out  32  load-hit data or refill data
- hit_ack  out  1  request completed this cycle
- miss_send  out  1  load miss accepted into MSHR
- passive_stall  out  1  request not accepted; pipeline holds it
- load_done_stall  out  1  refill completion injected this cycle
- regD_done  out  5  destination of completed refill
- mem_req  out  1  backing-memory request
- mem_we  out  1  1=write
- mem_addr  out  32  memory word address
- mem_wdata  out  32  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; in order, one read outstanding
- mem_rdata  in  32  read data

Behaviour:
- Reset (async): all cache valid bits 0; MSHR count/head/tail 0; FSM IDLE; refill register 0. All outputs 0.
- Outputs are combinational from state and current inputs. At most one of hit_ack/miss_send/passive_stall/load_done_stall is high per cycle. All four are 0 when mmio_req=0 and FSM≠DONE.
- Refill FSM:
  - IDLE: if MSHR non-empty, go to RD_ISSUE.
  - RD_ISSUE: mem_req=1, mem_we=0, mem_addr=head addr, held until mem_gnt, then go to RD_WAIT.
  - RD_WAIT: on mem_rvalid, latch mem_rdata, write the cache line (valid, tag, data) for the head addr at that edge, then go to DONE.
  - DONE (exactly 1 cycle): load_done_stall=1, regD_done=head regD, mmio_data_read=latched data. mmio_req is ignored this cycle. Head pops at the edge, then go to IDLE.
- Refill latency: mem_rvalid in cycle N gives load_done_stall in cycle N+1.
- Load request (FSM≠DONE):
  - Hit (valid and tag match): hit_ack=1, mmio_data_read=cached word, same cycle. Hit-under-miss is allowed.
  - Miss with count<MSHR_DEPTH: miss_send=1; enqueue {mmio_regD, mmio_addr} at the edge.
  - Miss with count==MSHR_DEPTH: passive_stall=1.
  - A load to an address already pending is a miss and enqueues a duplicate entry; both refills complete in order.
- Store request (FSM≠DONE):
  - Accepted only when FSM==IDLE and count==0; otherwise passive_stall=1.
  - When accepted: mem_req=1, mem_we=1, mem_addr/mem_wdata from the request.
  - mem_gnt=1: hit_ack=1. On a cache hit, update the data word at the edge. Write-no-allocate on miss.
  - mem_gnt=0: passive_stall=1; retried next cycle.
- The memory port is never double-driven: a store issues only in IDLE with MSHR empty, and the IDLE→RD_ISSUE transition is blocked that cycle.
- MSHR push and pop never coincide, because requests are ignored in DONE.
- Count never exceeds MSHR_DEPTH; head/tail wrap modulo MSHR_DEPTH.
- Reset mid-refill: queue, FSM and cache are cleared. Backing memory must be reset concurrently; any stale mem_rvalid after reset is undefined.
- mmio_data_read=0 when neither hit nor DONE.

Test Plan:
- Cold load addr 0x40, regD=5 → miss_send=1; mem_req read addr 0x40. With mem_rdata=0xCAFEF00D, the cycle after mem_rvalid gives load_done_stall=1, regD_done=5, mmio_data_read=0xCAFEF00D. Reload 0x40 → hit_ack=1 with the same data, no mem_req.
- Five distinct missing loads, mem_gnt held 0 → first four give miss_send; fifth gives passive_stall=1 until the first DONE pops an entry, then miss_send.
- Store 0x80 data 0x1234 with one MSHR entry pending → passive_stall until that entry's DONE. Then mem_req write; mem_gnt=1 gives hit_ack=1.
- Store hit to cached 0x40 with 0xAAAA5555 → memory write plus cache update; next load 0x40 gives hit_ack with 0xAAAA5555. Store miss to 0x100 then load 0x100 → miss (no allocate).
- Two loads to the same missing address (regD 3, then 7) → two reads, DONE with regD_done=3 then 7. A hit load issued during RD_WAIT gets hit_ack; a request during DONE gets no response.
- Assert rst during RD_WAIT with two entries queued → all outputs 0 immediately; after release, a load to the previously cached address misses.

Source files
------------

// File: rtl/dmem_mshr_ctrl.sv
// Data-memory controller: direct-mapped write-through cache with an in-order
// MSHR queue for non-blocking load misses, sharing one backing-memory port.
module dmem_mshr_ctrl #(
  parameter int SETS       = 16,
  parameter int MSHR_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_req,
  input  logic        mmio_lw,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_data_write,
  input  logic [4:0]  mmio_regD,
  output logic [31:0] mmio_data_read,
  output logic        hit_ack,
  output logic        miss_send,
  output logic        passive_stall,
  output logic        load_done_stall,
  output logic [4:0]  regD_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PTR_W = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
  localparam int CNT_W = $clog2(MSHR_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [SETS-1:0]     valid_r;
  logic [TAG_W-1:0]    tag_r  [SETS];
  logic [31:0]         data_r [SETS];
  logic [31:0]         q_addr_r [MSHR_DEPTH];
  logic [4:0]          q_regd_r [MSHR_DEPTH];
  logic [PTR_W-1:0]    head_r, tail_r;
  logic [CNT_W-1:0]    count_r;
  logic [31:0]         refill_data_r;

  logic [IDX_W-1:0]    req_idx_s, head_idx_s;
  logic [TAG_W-1:0]    req_tag_s, head_tag_s;
  logic [31:0]         head_addr_s;
  logic                hit_s, push_s, pop_s, fill_s, st_upd_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MSHR_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign req_idx_s   = mmio_addr[2 +: IDX_W];
  assign req_tag_s   = mmio_addr[31 -: TAG_W];
  assign head_addr_s = q_addr_r[head_r];
  assign head_idx_s  = head_addr_s[2 +: IDX_W];
  assign head_tag_s  = head_addr_s[31 -: TAG_W];
  assign hit_s       = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);

  // Refill sequencing plus same-cycle response to the pipeline request.
  always_comb begin
    state_s         = state_r;
    mmio_data_read  = 32'd0;
    hit_ack         = 1'b0;
    miss_send       = 1'b0;
    passive_stall   = 1'b0;
    load_done_stall = 1'b0;
    regD_done       = 5'd0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = 32'd0;
    mem_wdata       = 32'd0;
    push_s          = 1'b0;
    pop_s           = 1'b0;
    fill_s          = 1'b0;
    st_upd_s        = 1'b0;

    case (state_r)
      IDLE: begin
        // A store can only issue with count==0, so this never collides with it.
        if (count_r != CNT_W'(0)) begin
          state_s = RD_ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = head_addr_s;
        if (mem_gnt) begin
          state_s = RD_WAIT;
        end else begin
          state_s = RD_ISSUE;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          fill_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RD_WAIT;
        end
      end
      DONE: begin
        load_done_stall = 1'b1;
        regD_done       = q_regd_r[head_r];
        mmio_data_read  = refill_data_r;
        pop_s           = 1'b1;
        state_s         = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Requests are ignored during DONE, so a push never meets a pop.
    if (mmio_req && (state_r != DONE)) begin
      if (mmio_lw) begin
        if (hit_s) begin
          hit_ack        = 1'b1;
          mmio_data_read = data_r[req_idx_s];
        end else if (count_r < CNT_W'(MSHR_DEPTH)) begin
          miss_send = 1'b1;
          push_s    = 1'b1;
        end else begin
          passive_stall = 1'b1;
        end
      end else begin
        if ((state_r == IDLE) && (count_r == CNT_W'(0))) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = mmio_addr;
          mem_wdata = mmio_data_write;
          if (mem_gnt) begin
            hit_ack  = 1'b1;
            st_upd_s = hit_s;
          end else begin
            passive_stall = 1'b1;
          end
        end else begin
          passive_stall = 1'b1;
        end
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FSM state and latched refill word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      refill_data_r <= 32'd0;
    end else begin
      state_r <= state_s;
      if (fill_s) begin
        refill_data_r <= mem_rdata;
      end
    end
  end

  // Cache valid bits; stores never allocate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (fill_s) begin
      valid_r[head_idx_s] <= 1'b1;
    end
  end

  // Cache tag/data arrays, qualified by valid_r so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[head_idx_s]  <= head_tag_s;
      data_r[head_idx_s] <= mem_rdata;
    end else if (st_upd_s) begin
      data_r[req_idx_s] <= mmio_data_write;
    end
  end

  // MSHR entry storage, written at the tail on a miss.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_addr_r[tail_r] <= mmio_addr;
      q_regd_r[tail_r] <= mmio_regD;
    end
  end

  // MSHR pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
